fexp2_unit: RTL and testbench

FEXP2_UNIT -- requirements
Module: fexp2_unit

---
 rtl/flog_pkg.sv | 37 +++
 rtl/fexp2_lut.sv | 67 ++++++
 rtl/fexp2_unit.sv | 180 ++++++++++++++++++
 tb/tb_fexp2_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/flog_pkg.sv
// Purpose : shared widths, FSM state type and special-value constants for the fexp2 unit.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package flog_pkg;

    localparam int S_WIDTH     = 1;
    localparam int EXP_WIDTH   = 8;
    localparam int FRACT_WIDTH = 7;
    localparam int BIAS        = 127;

    // Biased exponent at which {1,fraction} already sits in Q7.16 unshifted
    // (2^(e-127) * M/2^7 * 2^16 = M * 2^(e-118)).
    localparam logic [EXP_WIDTH-1:0] EXP_ALIGN = 8'd118;
    // |x| >= 128 from here on: 2^x overflows / underflows bfloat16 outright.
    localparam logic [EXP_WIDTH-1:0] EXP_SAT   = 8'd134;
    localparam logic [EXP_WIDTH-1:0] EXP_MAX   = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        CLASSIFY,
        ALIGN,
        LOOKUP,
        DONE
    } state_t;

    typedef struct packed {
        logic                   s;
        logic [EXP_WIDTH-1:0]   e;
        logic [FRACT_WIDTH-1:0] f;
    } result_t;

    localparam result_t QNAN = '{s: 1'b0, e: 8'hFF, f: 7'h40};
    localparam result_t INF  = '{s: 1'b0, e: 8'hFF, f: 7'h00};
    localparam result_t ONE  = '{s: 1'b0, e: 8'h7F, f: 7'h00};
    localparam result_t ZERO = '{s: 1'b0, e: 8'h00, f: 7'h00};

endpackage

// File: rtl/fexp2_lut.sv
// Purpose : 256-entry fraction table, LUT[k] = round((2^(k/256)-1)*128) clamped to 127.
// Latency : combinational.
// Backpr. : none (pure lookup).
//
// Ports:
//   i_idx  [7:0] : table index (top 8 bits of the fractional part of x)
//   o_frac [6:0] : bfloat16 fraction of 2^(idx/256)
module fexp2_lut
    import flog_pkg::*;
(
    input  logic [7:0]             i_idx,
    output logic [FRACT_WIDTH-1:0] o_frac
);

    // The table is built at elaboration with integer arithmetic only.
    // Entry k is the count of v in 0..126 whose rounding threshold
    // t_v = 1 + (v+0.5)/128 satisfies t_v^256 <= 2^k, which equals
    // round((2^(k/256)-1)*128) capped at 127. t_v^256 is formed by eight
    // squarings of a Q1.62 mantissa with a separate power-of-two exponent.
    function automatic logic [255:0][6:0] build_lut();
        logic [255:0][6:0] tbl;
        logic [126:0][8:0] thr;
        logic [63:0]       m;
        logic [127:0]      p;
        int                e;
        int                v;
        logic              stop;
        tbl = '0;
        thr = '0;
        for (int i = 0; i < 127; i++) begin
            m = 64'(257 + 2 * i) << 54;
            e = 0;
            for (int s = 0; s < 8; s++) begin
                p = {64'd0, m} * {64'd0, m};
                if (p[125]) begin
                    m = p[126:63];
                    e = 2 * e + 1;
                end else begin
                    m = p[125:62];
                    e = 2 * e;
                end
            end
            // Smallest k with 2^k >= t_v^256.
            thr[7'(i)] = (m == 64'h4000_0000_0000_0000) ? 9'(e) : 9'(e + 1);
        end
        v = 0;
        for (int k = 0; k < 256; k++) begin
            stop = 1'b0;
            while (!stop) begin
                if (v >= 127) begin
                    stop = 1'b1;
                end else if (int'(thr[7'(v)]) > k) begin
                    stop = 1'b1;
                end else begin
                    v = v + 1;
                end
            end
            tbl[8'(k)] = 7'(v);
        end
        return tbl;
    endfunction

    localparam logic [255:0][6:0] LUT = build_lut();

    assign o_frac = LUT[i_idx];

endmodule

// File: rtl/fexp2_unit.sv
// Purpose : bfloat16 2^x, multi-cycle FSM (IDLE/CLASSIFY/ALIGN/LOOKUP/DONE).
// Latency : valid_o rises 3 clock edges after the capture edge, for every operand class.
// Backpr. : return-to-zero handshake; result held in DONE until valid_i drops, no re-capture meanwhile.
//
// Ports:
//   clk, rst (async, active low)
//   sign / exponent / fractional / valid_i : operand, valid held until valid_o seen
//   s_res_o / e_res_o / f_res_o / valid_o  : registered result (sign always 0)
//
// Build option: define FEXP2_ROUND_EN to round the table index (r[15:8]+r[7])
// instead of truncating it; latency is identical in both builds.
module fexp2_unit
    import flog_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [S_WIDTH-1:0]     sign,
    input  logic [EXP_WIDTH-1:0]   exponent,
    input  logic [FRACT_WIDTH-1:0] fractional,
    input  logic                   valid_i,
    output logic                   s_res_o,
    output logic [EXP_WIDTH-1:0]   e_res_o,
    output logic [FRACT_WIDTH-1:0] f_res_o,
    output logic                   valid_o
);

    state_t                 r_state;
    logic                   r_sign;
    logic [EXP_WIDTH-1:0]   r_exp;
    logic [FRACT_WIDTH-1:0] r_frac;
    logic                   r_special;
    result_t                r_spec_res;
    logic [23:0]            r_xq;
    result_t                r_res;
    logic                   r_valid;

    // ---------------- CLASSIFY: special operands bypass the datapath ----------
    logic    w_special;
    result_t w_spec_res;

    always_comb begin
        w_special  = 1'b1;
        w_spec_res = ONE;
        if (r_exp == EXP_MAX) begin
            if (r_frac != '0) begin
                w_spec_res = QNAN;
            end else begin
                w_spec_res = r_sign ? ZERO : INF;
            end
        end else if (r_exp == '0) begin
            // Zero and denormals are treated as x = 0.
            w_spec_res = ONE;
        end else if (r_exp >= EXP_SAT) begin
            w_spec_res = r_sign ? ZERO : INF;
        end else begin
            w_special = 1'b0;
        end
    end

    // ---------------- ALIGN: fixed-point x in signed Q8.16 -------------------
    logic [22:0] w_mant;
    logic [22:0] w_mag;
    logic [23:0] w_xq;

    assign w_mant = {15'd0, 1'b1, r_frac};

    // Non-special exponents are <= 133, so a left shift is at most 15 and the
    // magnitude stays below 2^23. Right shifts truncate toward zero.
    always_comb begin
        if (r_exp >= EXP_ALIGN) begin
            w_mag = w_mant << (r_exp - EXP_ALIGN);
        end else begin
            w_mag = w_mant >> (EXP_ALIGN - r_exp);
        end
    end

    assign w_xq = r_sign ? (24'd0 - {1'b0, w_mag}) : {1'b0, w_mag};

    // ---------------- LOOKUP: split x into integer n and fraction r ----------
    // n = floor(xq / 2^16) is simply the top byte of the two's-complement value.
    logic [7:0]             w_n;
    logic [7:0]             w_idx;
    logic                   w_carry;
    logic [9:0]             w_eb;
    logic [FRACT_WIDTH-1:0] w_lut_frac;
    result_t                w_look;
    logic                   w_unused_lsbs;

    assign w_n = r_xq[23:16];

`ifdef FEXP2_ROUND_EN
    logic [8:0] w_idx_sum;
    // Rounding can carry r up to 1.0: wrap idx to 0 and bump n instead.
    assign w_idx_sum     = {1'b0, r_xq[15:8]} + {8'd0, r_xq[7]};
    assign w_idx         = w_idx_sum[7:0];
    assign w_carry       = w_idx_sum[8];
    assign w_unused_lsbs = ^r_xq[6:0];
`else
    assign w_idx         = r_xq[15:8];
    assign w_carry       = 1'b0;
    assign w_unused_lsbs = ^r_xq[7:0];
`endif

    // Biased result exponent as signed 10-bit; n+127(+1) spans -1..255.
    assign w_eb = {{2{w_n[7]}}, w_n} + 10'(BIAS) + {9'd0, w_carry};

    fexp2_lut u_lut (
        .i_idx  (w_idx),
        .o_frac (w_lut_frac)
    );

    always_comb begin
        w_look = ZERO;
        if (w_eb[9] || (w_eb == 10'd0)) begin
            w_look = ZERO;           // below the normal range: flush to +0
        end else if (w_eb >= 10'd255) begin
            w_look = INF;
        end else begin
            w_look.s = 1'b0;
            w_look.e = w_eb[7:0];
            w_look.f = w_lut_frac;
        end
    end

    // ---------------- FSM with registered outputs ---------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_frac     <= '0;
            r_special  <= 1'b0;
            r_spec_res <= ZERO;
            r_xq       <= '0;
            r_res      <= ZERO;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_sign  <= sign[S_WIDTH-1];
                        r_exp   <= exponent;
                        r_frac  <= fractional;
                        r_state <= CLASSIFY;
                    end
                end
                CLASSIFY: begin
                    r_special  <= w_special;
                    r_spec_res <= w_spec_res;
                    r_state    <= ALIGN;
                end
                ALIGN: begin
                    r_xq    <= w_xq;
                    r_state <= LOOKUP;
                end
                LOOKUP: begin
                    r_res   <= r_special ? r_spec_res : w_look;
                    r_valid <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    if (!valid_i) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_res_o = r_res.s;
    assign e_res_o = r_res.e;
    assign f_res_o = r_res.f;
    assign valid_o = r_valid;

endmodule

// File: tb/tb_fexp2_unit.sv
// Directed and random operands against a real-arithmetic model of 2^x in bfloat16.
module tb_fexp2_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [0:0] sign = '0;
    logic [7:0] exponent = '0;
    logic [6:0] fractional = '0;
    logic       valid_i = 1'b0;
    logic       s_res_o;
    logic [7:0] e_res_o;
    logic [6:0] f_res_o;
    logic       valid_o;

    int checks = 0;
    int errors = 0;

    fexp2_unit dut (
        .clk        (clk),
        .rst        (rst),
        .sign       (sign),
        .exponent   (exponent),
        .fractional (fractional),
        .valid_i    (valid_i),
        .s_res_o    (s_res_o),
        .e_res_o    (e_res_o),
        .f_res_o    (f_res_o),
        .valid_o    (valid_o)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] R_QNAN = 16'h7FC0;
    localparam logic [15:0] R_INF  = 16'h7F80;
    localparam logic [15:0] R_ONE  = 16'h3F80;
    localparam logic [15:0] R_ZERO = 16'h0000;

    function automatic logic [6:0] lut_ref(input int k);
        real y;
        int  v;
        y = (2.0 ** (real'(k) / 256.0) - 1.0) * 128.0;
        v = $rtoi(y + 0.5);
        if (v > 127) v = 127;
        return 7'(v);
    endfunction

    // Reference: evaluate x as a real, quantise to Q16 by truncating the
    // magnitude, then split into floor integer part and fraction.
    function automatic logic [15:0] model(input logic s, input logic [7:0] e, input logic [6:0] f);
        real ax;
        int  mag, xq, n, r, idx, eb;
        if (e == 8'd255) return (f != 7'd0) ? R_QNAN : (s ? R_ZERO : R_INF);
        if (e == 8'd0) return R_ONE;
        if (e >= 8'd134) return s ? R_ZERO : R_INF;
        ax  = (1.0 + real'(f) / 128.0) * (2.0 ** real'(int'(e) - 127));
        mag = $rtoi(ax * 65536.0);
        xq  = s ? -mag : mag;
        n   = $rtoi($floor(real'(xq) / 65536.0));
        r   = xq - n * 65536;
`ifdef FEXP2_ROUND_EN
        idx = (r + 128) / 256;
        if (idx == 256) begin
            idx = 0;
            n   = n + 1;
        end
`else
        idx = r / 256;
`endif
        eb = n + 127;
        if (eb <= 0) return R_ZERO;
        if (eb >= 255) return R_INF;
        return {1'b0, 8'(eb), lut_ref(idx)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full handshake: present operand, scramble inputs after capture,
    // measure latency, check result, then drop valid_i.
    task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                          input logic [6:0] f, input logic [15:0] exp_res);
        int   lat;
        logic seen;
        sign       = s;
        exponent   = e;
        fractional = f;
        valid_i    = 1'b1;
        @(posedge clk); #1;
        sign       = 1'($urandom);
        exponent   = 8'($urandom);
        fractional = 7'($urandom);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            seen = valid_o;
        end
        check({tag, " latency"}, 32'(lat), 32'd3);
        check({tag, " result"}, {16'd0, s_res_o, e_res_o, f_res_o}, {16'd0, exp_res});
        valid_i = 1'b0;
        @(posedge clk); #1;
        check({tag, " valid_o drop"}, {31'd0, valid_o}, 32'd0);
    endtask

    initial begin
        logic        rs;
        logic [7:0]  re;
        logic [6:0]  rf;
        logic [15:0] hold_exp;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset valid_o", {31'd0, valid_o}, 32'd0);
        check("reset result", {16'd0, s_res_o, e_res_o, f_res_o}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle after reset", {31'd0, valid_o}, 32'd0);

        // Directed operands
        run_op("zero",        1'b0, 8'd0,   7'h00, R_ONE);
        run_op("neg denorm",  1'b1, 8'd0,   7'h12, R_ONE);
        run_op("one",         1'b0, 8'd127, 7'h00, 16'h4000);
        run_op("minus one",   1'b1, 8'd127, 7'h00, 16'h3F00);
        run_op("half",        1'b0, 8'd126, 7'h00, 16'h3FB5);
        run_op("+inf",        1'b0, 8'd255, 7'h00, R_INF);
        run_op("-inf",        1'b1, 8'd255, 7'h00, R_ZERO);
        run_op("qnan",        1'b0, 8'd255, 7'h40, R_QNAN);
        run_op("snan",        1'b0, 8'd255, 7'h3F, R_QNAN);
        run_op("sat +200",    1'b0, 8'd134, 7'h48, R_INF);
        run_op("sat -200",    1'b1, 8'd134, 7'h48, R_ZERO);
        run_op("-127.5",      1'b1, 8'd133, 7'h7F, R_ZERO);
        run_op("+127.5",      1'b0, 8'd133, 7'h7F, 16'h7F35);
        run_op("e118",        1'b0, 8'd118, 7'h00, model(1'b0, 8'd118, 7'h00));
        run_op("neg frac",    1'b1, 8'd120, 7'h55, model(1'b1, 8'd120, 7'h55));

        // Random operands, mostly in the interesting exponent band
        for (int i = 0; i < 60; i++) begin
            rs = 1'($urandom);
            re = (i % 4 == 0) ? 8'($urandom) : 8'($urandom_range(136, 110));
            rf = 7'($urandom);
            run_op("random", rs, re, rf, model(rs, re, rf));
        end

        // valid_i held for 10 cycles: single result, held until valid_i drops
        hold_exp   = model(1'b0, 8'd128, 7'h20);
        sign       = 1'b0;
        exponent   = 8'd128;
        fractional = 7'h20;
        valid_i    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("hold valid_o", {31'd0, valid_o}, 32'(c >= 3));
            if (c >= 3) check("hold result", {16'd0, s_res_o, e_res_o, f_res_o}, {16'd0, hold_exp});
        end
        valid_i = 1'b0;
        @(posedge clk); #1;
        check("hold release", {31'd0, valid_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("hold no recapture", {31'd0, valid_o}, 32'd0);

        // Reset pulse while the operation is in ALIGN
        sign       = 1'b1;
        exponent   = 8'd129;
        fractional = 7'h10;
        valid_i    = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid reset valid_o", {31'd0, valid_o}, 32'd0);
        check("mid reset result", {16'd0, s_res_o, e_res_o, f_res_o}, 32'd0);
        valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("discarded operand", {31'd0, valid_o}, 32'd0);
        end
        run_op("after reset", 1'b0, 8'd128, 7'h40, model(1'b0, 8'd128, 7'h40));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
